sonar_scheduler: RTL and testbench
==================================

// Module: sonar_scheduler
// PURPOSE
//  Round-robin sequencer for N_SONAR ultrasonic rangefinders on the robot.
//  - Fires one sensor at a time so sensors do not pick up each other's pings.
//  - Generates each trigger pulse and times the echo-high width in clk cycles.
//  - Applies a per-sensor timeout.
//  - Publishes one 32-bit distance register per sensor, plus a result strobe.
// PARAMETERS
//  N_SONAR          4          number of sensors, 1..8
//  DIST_W           32         distance register width
//  TRIG_CYCLES      500        trigger high time (10 us @ 50 MHz)
//  ARM_TIMEOUT      1_000_000  max cycles from trigger fall to echo rise (20 ms)
//  ECHO_MAX         1_900_000  max echo-high cycles (38 ms); beyond = no target
//  GAP_CYCLES       500_000    idle cycles after each sensor before the next fires (10 ms)
// PORTS
//  clk       in   1               system clock, 50 MHz
//  reset     in   1               synchronous, active-high
//  enable    in   1               1 = run continuous round-robin
//  echo      in   N_SONAR         raw echo lines, asynchronous
//  trigger   out  N_SONAR         trigger lines; at most one high at any time
//  distance  out  N_SONAR*DIST_W  sensor i in [i*DIST_W +: DIST_W]; echo width in cycles
//  valid     out  N_SONAR         1-cycle strobe when distance[i] is updated
//  timeout   out  N_SONAR         sticky per sensor: last result was a timeout
//  active    out  $clog2(N_SONAR) index of the sensor currently being serviced
//  mask      in   N_SONAR         present only with SONAR_MASK_EN
// BEHAVIOUR
//  Reset values (next clk edge with reset=1): trigger=0, valid=0, timeout=0,
//  distance=0, active=0, state=IDLE, all counters=0.
//  - Reset mid-measurement aborts it and drops trigger at that edge.
//  Echo input: each bit passes through a 2-flop synchroniser. All echo
//  references below mean the synchronised signal, 2 cycles behind the pin.
//  FSM states (one cycle-counter cnt, cleared on every state entry):
//  - IDLE: when enable=1, go to TRIG for sensor `active`.
//  - TRIG: trigger[active]=1 for exactly TRIG_CYCLES cycles, then WAIT.
//  - WAIT: needs a 0->1 transition of echo[active].
//    - echo already high on entry counts only once it has gone low and risen again.
//    - Rise seen -> MEAS with cnt=1.
//    - cnt reaches ARM_TIMEOUT -> TOUT.
//  - MEAS: cnt increments each cycle while echo=1.
//    - On echo 1->0: distance[active]=cnt, valid[active]=1 for 1 cycle,
//      timeout[active]=0, go to GAP.
//    - cnt reaches ECHO_MAX while echo still high -> TOUT.
//  - TOUT: distance[active]=all-ones, valid[active]=1, timeout[active]=1, go to GAP.
//  - GAP: wait GAP_CYCLES, then active = (active+1) mod N_SONAR.
//    - enable=1: go to TRIG.
//    - enable=0: go to IDLE.
//  enable is sampled only in IDLE and at the end of GAP. Dropping it mid-sensor
//  completes that sensor's measurement normally.
//  Result timing: for an echo pin high for exactly W cycles (W < ECHO_MAX),
//  distance = W exactly, and valid asserts 3 cycles after the pin falls.
//  Counter width = DIST_W; ECHO_MAX < 2**DIST_W-1, so cnt never wraps.
//  distance[i] holds its value until sensor i's next result; other sensors'
//  registers are never disturbed.
// CONFIGURATION
//  SONAR_MASK_EN defined: the mask port exists.
//  - A sensor with mask[i]=0 is skipped; round-robin advances to the next set bit.
//  - mask=0 everywhere: stay in IDLE.
//  - mask is sampled at the same points as enable.
//  - distance[i] of a masked sensor is held.
//  SONAR_MASK_EN undefined: no mask port; every sensor is serviced.
// STRUCTURE
//  Package sonar_pkg:
//  - typedef enum sonar_state_t {IDLE, TRIG, WAIT, MEAS, TOUT, GAP}
//  - localparam CLK_HZ = 50_000_000 and default timing constants
//  - DIST_TIMEOUT = '1
//  Sub-module sonar_echo_sync: per-bit 2-flop synchroniser with rise/fall
//  detect, instantiated once with width N_SONAR.
// TESTING (bench overrides: TRIG_CYCLES=5, ARM_TIMEOUT=100, ECHO_MAX=1000, GAP_CYCLES=20)
//  1. reset then enable=1; sensor 0 echo high 300 cycles
//     -> trigger[0] high exactly 5 cycles; distance[0]=300; valid[0] 1 cycle;
//        trigger[1] rises 20 cycles later.
//  2. sensor 1 never echoes
//     -> after 100 cycles in WAIT: distance[1]=32'hFFFF_FFFF, timeout[1]=1, sensor 2 fires.
//  3. sensor 2 echo stuck high 1500 cycles
//     -> TOUT at ECHO_MAX: distance[2]=all-ones, timeout[2]=1.
//  4. echo[3] pulsed while sensor 0 active, plus full 4-sensor sweep
//     -> stray pulse ignored; trigger is one-hot or zero at every cycle;
//        active order 0,1,2,3,0.
//  5. reset asserted mid-MEAS
//     -> next edge: trigger=0, all distance=0, active=0; after release and enable,
//        restart at sensor 0.
//  6. SONAR_MASK_EN, mask=4'b0101
//     -> only triggers 0 and 2 ever fire; distance[1], distance[3] remain 0.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared types and default timing for the sonar round-robin scheduler.
// Defaults assume a 50 MHz system clock.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT,
    MEAS,
    TOUT,
    GAP
  } sonar_state_t;

  localparam int CLK_HZ = 50_000_000;

  // 10 us trigger, 20 ms arm window, 38 ms echo ceiling, 10 ms inter-sensor gap
  localparam int DEF_TRIG_CYCLES = CLK_HZ / 100_000;
  localparam int DEF_ARM_TIMEOUT = CLK_HZ / 50;
  localparam int DEF_ECHO_MAX    = (CLK_HZ / 1000) * 38;
  localparam int DEF_GAP_CYCLES  = CLK_HZ / 100;

  // Fill bit replicated across a distance register to mark "no target"
  localparam bit DIST_TIMEOUT = '1;

endpackage

// File: rtl/sonar_echo_sync.sv
// Two-flop synchroniser for the asynchronous echo lines, followed by a
// history flop so rising and falling edges of the synchronised level can
// be reported as single-cycle pulses.
module sonar_echo_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] echo_i,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  // Synchroniser chain plus one cycle of history for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin sequencer for N_SONAR ultrasonic rangefinders: fires one
// trigger at a time, times the synchronised echo-high width, applies arm and
// echo timeouts and publishes one distance register per sensor.
// Optional feature: define SONAR_MASK_EN to add the mask port, which skips
// sensors whose mask bit is 0.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int N_SONAR     = 4,
  parameter int DIST_W      = 32,
  parameter int TRIG_CYCLES = DEF_TRIG_CYCLES,
  parameter int ARM_TIMEOUT = DEF_ARM_TIMEOUT,
  parameter int ECHO_MAX    = DEF_ECHO_MAX,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  localparam int ACT_W      = (N_SONAR > 1) ? $clog2(N_SONAR) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [N_SONAR-1:0]          echo,
`ifdef SONAR_MASK_EN
  input  logic [N_SONAR-1:0]          mask,
`endif
  output logic [N_SONAR-1:0]          trigger,
  output logic [N_SONAR*DIST_W-1:0]   distance,
  output logic [N_SONAR-1:0]          valid,
  output logic [N_SONAR-1:0]          timeout,
  output logic [ACT_W-1:0]            active
);

  sonar_state_t        state_q, state_d;
  logic [DIST_W-1:0]   cnt_q, cnt_d;
  logic [ACT_W-1:0]    active_q, active_d;
  logic [DIST_W-1:0]   dist_q [N_SONAR];
  logic [N_SONAR-1:0]  valid_q;
  logic [N_SONAR-1:0]  tout_q;

  logic [N_SONAR-1:0]  echoRise;
  logic [N_SONAR-1:0]  echoFall;
  logic [N_SONAR-1:0]  svcMask;

  logic                resultLoad;
  logic                resultTout;
  logic [DIST_W-1:0]   resultVal;

  sonar_echo_sync #(
    .WIDTH(N_SONAR)
  ) u_echo_sync (
    .clk   (clk),
    .reset (reset),
    .echo_i(echo),
    .rise_o(echoRise),
    .fall_o(echoFall)
  );

`ifdef SONAR_MASK_EN
  assign svcMask = mask;
`else
  assign svcMask = '1;
`endif

  // First serviceable sensor at or after cur+offset, wrapping; keeps cur if none
  function automatic logic [ACT_W-1:0] pickSensor(input logic [ACT_W-1:0] cur,
                                                  input logic [N_SONAR-1:0] m,
                                                  input int offset);
    logic [ACT_W-1:0] sel;
    int               idx;
    sel = cur;
    for (int k = N_SONAR - 1; k >= 0; k--) begin
      idx = (int'(cur) + offset + k) % N_SONAR;
      if (m[idx]) sel = ACT_W'(idx);
    end
    return sel;
  endfunction

  // State, shared cycle counter and current-sensor index
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  // Sequencing: trigger, wait for a fresh echo rise, time it, then idle gap
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (enable && (|svcMask)) begin
          active_d = pickSensor(active_q, svcMask, 0);
          state_d  = TRIG;
          cnt_d    = '0;
        end
      end
      TRIG: begin
        if (cnt_q == DIST_W'(TRIG_CYCLES - 1)) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DIST_W'(1);
        end
      end
      WAIT: begin
        if (echoRise[active_q]) begin
          state_d = MEAS;
          cnt_d   = DIST_W'(1);
        end else if (cnt_q == DIST_W'(ARM_TIMEOUT - 1)) begin
          state_d = TOUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DIST_W'(1);
        end
      end
      MEAS: begin
        if (echoFall[active_q]) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt_q == DIST_W'(ECHO_MAX)) begin
          state_d = TOUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DIST_W'(1);
        end
      end
      TOUT: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        if (cnt_q == DIST_W'(GAP_CYCLES - 1)) begin
          cnt_d    = '0;
          active_d = pickSensor(active_q, svcMask, 1);
          state_d  = (enable && (|svcMask)) ? TRIG : IDLE;
        end else begin
          cnt_d = cnt_q + DIST_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Trigger line of the active sensor and the result write for this cycle
  always_comb begin
    trigger    = '0;
    resultLoad = 1'b0;
    resultTout = 1'b0;
    resultVal  = cnt_q;
    if (state_q == TRIG) trigger[active_q] = 1'b1;
    if (state_q == MEAS && echoFall[active_q]) begin
      resultLoad = 1'b1;
    end else if (state_q == TOUT) begin
      resultLoad = 1'b1;
      resultTout = 1'b1;
      resultVal  = {DIST_W{DIST_TIMEOUT}};
    end
  end

  // Per-sensor result registers; only the active sensor's slot is written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SONAR; i++) dist_q[i] <= '0;
      valid_q <= '0;
      tout_q  <= '0;
    end else begin
      valid_q <= '0;
      if (resultLoad) begin
        dist_q[active_q]  <= resultVal;
        valid_q[active_q] <= 1'b1;
        tout_q[active_q]  <= resultTout;
      end
    end
  end

  for (genvar g = 0; g < N_SONAR; g++) begin : g_dist
    assign distance[g*DIST_W +: DIST_W] = dist_q[g];
  end

  assign valid   = valid_q;
  assign timeout = tout_q;
  assign active  = active_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench for sonar_scheduler with shortened timing. The bench
// plays the role of the sensors: it answers each trigger with a randomly
// chosen echo (normal width, no echo, or stuck high) and compares the DUT
// against a per-sensor model of distances, timeout flags and service order.
// Build with SONAR_MASK_EN defined to exercise the mask (4'b0101).
module tb_sonar_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TC = 5;
  localparam int AT = 100;
  localparam int EM = 1000;
  localparam int GC = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [N-1:0]      echo;
  logic [N-1:0]      trigger;
  logic [N*DW-1:0]   distance;
  logic [N-1:0]      valid;
  logic [N-1:0]      timeout;
  logic [1:0]        active;
`ifdef SONAR_MASK_EN
  logic [N-1:0]      benchMask = 4'b0101;
`else
  logic [N-1:0]      benchMask = 4'b1111;
`endif

  int                checks = 0;
  int                failures = 0;
  bit                monOn = 1'b0;
  logic [DW-1:0]     expDist [N];
  logic [N-1:0]      expTout;

  sonar_scheduler #(
    .N_SONAR    (N),
    .DIST_W     (DW),
    .TRIG_CYCLES(TC),
    .ARM_TIMEOUT(AT),
    .ECHO_MAX   (EM),
    .GAP_CYCLES (GC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .echo    (echo),
`ifdef SONAR_MASK_EN
    .mask    (benchMask),
`endif
    .trigger (trigger),
    .distance(distance),
    .valid   (valid),
    .timeout (timeout),
    .active  (active)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Next serviced sensor: next set mask bit after i, cyclically
  function automatic int nextIdx(input int i);
    for (int k = 1; k <= N; k++) begin
      if (benchMask[(i + k) % N]) return (i + k) % N;
    end
    return i;
  endfunction

  // Every cycle: at most one trigger, and never on a masked sensor
  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("trig_onehot", 64'($onehot0(trigger)), 64'd1);
      checkOutput("trig_masked", 64'(trigger & ~benchMask), 64'd0);
    end
  end

  task automatic checkModel(input int idx);
    checkOutput($sformatf("valid_sel%0d", idx), 64'(valid), 64'(1 << idx));
    checkOutput("timeout_vec", 64'(timeout), 64'(expTout));
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("dist%0d", i), 64'(distance[i*DW +: DW]), 64'(expDist[i]));
  endtask

  // kind 0: echo of width w after dly cycles (with a stray pulse on another line)
  // kind 1: no echo at all; kind 2: echo stuck high past the echo ceiling
  task automatic applyStimulus(input int idx, input int kind, input int w,
                               input int dly, input bit goIdle);
    int n;
    int other;
    n = 0;
    while (trigger == '0 && n < GC + TC + 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("trig_sel", 64'(trigger), 64'(1 << idx));
    checkOutput("active", 64'(active), 64'(idx));
    n = 0;
    while (trigger != '0 && n < TC + 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("trig_len", 64'(n), 64'(TC));

    if (kind == 0) begin
      other = (idx + 1 + $urandom_range(0, N - 2)) % N;
      echo[other] = 1'b1;
      repeat (2) @(negedge clk);
      echo[other] = 1'b0;
      repeat (dly) @(negedge clk);
      echo[idx] = 1'b1;
      repeat (w) @(negedge clk);
      echo[idx] = 1'b0;
      n = 0;
      while (valid == '0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      checkOutput("valid_latency", 64'(n), 64'd3);
      expDist[idx] = DW'(w);
      expTout[idx] = 1'b0;
    end else if (kind == 1) begin
      n = 0;
      while (valid == '0 && n < AT + 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput("arm_timeout_latency", 64'(n), 64'(AT + 1));
      expDist[idx] = '1;
      expTout[idx] = 1'b1;
    end else begin
      repeat (dly) @(negedge clk);
      echo[idx] = 1'b1;
      n = 0;
      while (valid == '0 && n < EM + 20) begin
        @(negedge clk);
        n++;
      end
      echo[idx] = 1'b0;
      checkOutput("echo_max_latency", 64'(n), 64'(EM + 4));
      expDist[idx] = '1;
      expTout[idx] = 1'b1;
    end

    checkModel(idx);
    @(negedge clk);
    checkOutput("valid_pulse", 64'(valid), 64'd0);

    if (!goIdle) begin
      n = 1;
      while (trigger == '0 && n < GC + 10) begin
        @(negedge clk);
        n++;
      end
      checkOutput("gap_len", 64'(n), 64'(GC));
    end else begin
      n = 0;
      repeat (GC + 30) begin
        @(negedge clk);
        if (trigger != '0) n++;
      end
      checkOutput("idle_quiet", 64'(n), 64'd0);
      checkOutput("idle_active", 64'(active), 64'(nextIdx(idx)));
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idx;
    int r;
    int n;
    reset  = 1'b1;
    enable = 1'b0;
    echo   = '0;
    for (int i = 0; i < N; i++) expDist[i] = '0;
    expTout = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_trigger", 64'(trigger), 64'd0);
    checkOutput("rst_valid", 64'(valid), 64'd0);
    checkOutput("rst_timeout", 64'(timeout), 64'd0);
    checkOutput("rst_active", 64'(active), 64'd0);
    checkOutput("rst_distance", 64'(distance[63:0]), 64'd0);
    checkOutput("rst_distance_hi", 64'(distance[127:64]), 64'd0);
    reset = 1'b0;
    monOn = 1'b1;
    enable = 1'b1;

    // Directed opening sweep: normal 300, silent, stuck high, normal
    idx = 0;
    applyStimulus(idx, 0, 300, 10, 1'b0);
    idx = nextIdx(idx);
    applyStimulus(idx, 1, 0, 0, 1'b0);
    idx = nextIdx(idx);
    applyStimulus(idx, 2, 0, 5, 1'b0);
    idx = nextIdx(idx);
    applyStimulus(idx, 0, 123, 40, 1'b0);

    // Randomised sweeps
    for (int t = 0; t < 14; t++) begin
      idx = nextIdx(idx);
      r = $urandom_range(0, 9);
      if (r < 7) applyStimulus(idx, 0, $urandom_range(1, 400), $urandom_range(0, 60), 1'b0);
      else if (r < 9) applyStimulus(idx, 1, 0, 0, 1'b0);
      else applyStimulus(idx, 2, 0, $urandom_range(0, 30), 1'b0);
    end

    // Drop enable while a sensor is already triggered: it still completes
    idx = nextIdx(idx);
    enable = 1'b0;
    applyStimulus(idx, 0, 50, 5, 1'b1);

    // Restart, then reset in the middle of a measurement
    idx = nextIdx(idx);
    enable = 1'b1;
    n = 0;
    while (trigger == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resume_sel", 64'(trigger), 64'(1 << idx));
    n = 0;
    while (trigger != '0 && n < TC + 10) begin
      @(negedge clk);
      n++;
    end
    echo[idx] = 1'b1;
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    echo = '0;
    checkOutput("midrst_trigger", 64'(trigger), 64'd0);
    checkOutput("midrst_valid", 64'(valid), 64'd0);
    checkOutput("midrst_timeout", 64'(timeout), 64'd0);
    checkOutput("midrst_active", 64'(active), 64'd0);
    checkOutput("midrst_dist_lo", 64'(distance[63:0]), 64'd0);
    checkOutput("midrst_dist_hi", 64'(distance[127:64]), 64'd0);
    for (int i = 0; i < N; i++) expDist[i] = '0;
    expTout = '0;
    reset = 1'b0;

    idx = 0;
    applyStimulus(idx, 0, 77, 3, 1'b0);
    idx = nextIdx(idx);
    applyStimulus(idx, 0, 200, 20, 1'b0);

    monOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
